// File: rtl/cla_subtractor16_mp_pkg.sv
// Shared constants and types for the streaming multi-precision subtractor.
package cla_subtractor16_mp_pkg;
  localparam int LIMB_W = 16;

  localparam logic [0:0] ST_START = 1'b0;
  localparam logic [0:0] ST_MID   = 1'b1;

  typedef struct packed {
    logic [LIMB_W-1:0] diff;
    logic              borrow;
    logic              last;
    logic              zero;
    logic              negative;
    logic              overflow;
  } res_t;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (a_msb ^ d_msb);
  endfunction
endpackage

// File: rtl/cla_subtractor16_mp_if.sv
// Limb-stream bus: operand limbs in, difference limbs and flags out.
interface cla_subtractor16_mp_if;
  import cla_subtractor16_mp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [LIMB_W-1:0] a;
  logic [LIMB_W-1:0] b;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [LIMB_W-1:0] diff;
  logic              out_last;
  logic              borrow_out;
  logic              zero;
  logic              negative;
  logic              overflow;

  modport master (
    output in_valid, a, b, in_last, out_ready,
    input  in_ready, out_valid, diff, out_last, borrow_out, zero, negative, overflow
  );

  modport slave (
    input  in_valid, a, b, in_last, out_ready,
    output in_ready, out_valid, diff, out_last, borrow_out, zero, negative, overflow
  );
endinterface

// File: rtl/cla_adder16.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups, lookahead across groups.
module cla_adder16
  import cla_subtractor16_mp_pkg::*;
(
  output logic [LIMB_W-1:0] sum,
  output logic              carry_out,
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin
);
  localparam int GW = 4;
  localparam int NG = LIMB_W / GW;

  logic [LIMB_W-1:0] g, p, c;
  logic [NG-1:0]     gg, gp;
  logic [NG:0]       gc;

  assign g = a & b;
  assign p = a ^ b;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B0 = k * GW;
    assign gp[k] = &p[B0 +: GW];
    assign gg[k] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                 | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);

    // In-group carries expanded from the group carry-in, no bit-to-bit ripple.
    assign c[B0]   = gc[k];
    assign c[B0+1] = g[B0] | (p[B0] & gc[k]);
    assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & gc[k]);
    assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                   | (p[B0+2] & p[B0+1] & p[B0] & gc[k]);
  end

  always_comb begin
    gc[0] = cin;
    for (int k = 0; k < NG; k++) gc[k+1] = gg[k] | (gp[k] & gc[k]);
  end

  assign sum       = p ^ c;
  assign carry_out = gc[NG];
endmodule

// File: rtl/my_not.sv
// Bitwise inverter cell.
module my_not #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = ~a;
endmodule

// File: rtl/cla_subtractor16_mp.sv
// Streaming A-B over LSB-first 16-bit limbs; borrow chained between beats,
// whole-operand zero/negative/overflow reported on the top limb.
module cla_subtractor16_mp
  import cla_subtractor16_mp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cla_subtractor16_mp_if.slave bus
);
  logic [0:0]        state_q, state_d;
  logic              borrow_q, borrow_d;
  logic              zero_acc_q, zero_acc_d;
  logic              out_valid_q, out_valid_d;
  res_t              res_q, res_d;

  logic              accept, bin, cin, carry, zero_nxt;
  logic [LIMB_W-1:0] b_n, sum;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bin = (state_q == ST_START) ? 1'b0 : borrow_q;

  // a - b - bin == a + ~b + !bin
  my_not #(.W(LIMB_W)) u_not_b   (.a(bus.b), .y(b_n));
  my_not #(.W(1))      u_not_bin (.a(bin),   .y(cin));

  cla_adder16 u_add (
    .sum      (sum),
    .carry_out(carry),
    .a        (bus.a),
    .b        (b_n),
    .cin      (cin)
  );

  assign zero_nxt = ((state_q == ST_START) ? 1'b1 : zero_acc_q) & (sum == '0);

  always_comb begin
    state_d     = state_q;
    borrow_d    = borrow_q;
    zero_acc_d  = zero_acc_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (accept) begin
      state_d        = bus.in_last ? ST_START : ST_MID;
      borrow_d       = ~carry;
      zero_acc_d     = bus.in_last ? 1'b1 : zero_nxt;
      out_valid_d    = 1'b1;
      res_d          = '0;
      res_d.diff     = sum;
      res_d.borrow   = ~carry;
      res_d.last     = bus.in_last;
      if (bus.in_last) begin
        res_d.zero     = zero_nxt;
        res_d.negative = sum[LIMB_W-1];
        res_d.overflow = signed_ovf(bus.a[LIMB_W-1], bus.b[LIMB_W-1], sum[LIMB_W-1]);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      borrow_q    <= 1'b0;
      zero_acc_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      borrow_q    <= borrow_d;
      zero_acc_q  <= zero_acc_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.diff       = res_q.diff;
  assign bus.borrow_out = res_q.borrow;
  assign bus.out_last   = res_q.last;
  assign bus.zero       = res_q.zero;
  assign bus.negative   = res_q.negative;
  assign bus.overflow   = res_q.overflow;
endmodule
